viewport_ctrl: RTL and testbench

Per-frame viewport sequencer that sits directly upstream of `pixel_scheduler`. It owns the auto-zoom state: viewport origin, pixel step and max-iteration budget. It issues `frame_start`, waits for the scheduler's completion, computes the next zoomed viewport with a multi-cycle shift-add multiplier, then starts the next frame. It replaces the inline zoom logic in the top level and frees the ARM-facing register path (Phase 4) from hardwired constants.

---
 rtl/viewport_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_viewport_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/viewport_ctrl.sv
// Per-frame viewport sequencer: starts a frame, waits for the scheduler, then computes the
// next auto-zoomed viewport with a shift-add multiplier. Optional ramp: VIEWPORT_ITER_RAMP_EN.
module viewport_ctrl #(
   parameter int               WIDTH        = 32,
   parameter int               ITER_W       = 16,
   parameter int               H_RES        = 320,
   parameter int               V_RES        = 172,
   parameter int               ZOOM_SHIFT   = 6,
   parameter logic [WIDTH-1:0] TARGET_RE    = 32'hF4147AE1,
   parameter logic [WIDTH-1:0] TARGET_IM    = 32'h01CFDF3B,
   parameter logic [WIDTH-1:0] DEF_RE_START = 32'hE0000000,
   parameter logic [WIDTH-1:0] DEF_IM_START = 32'hF319999A,
   parameter logic [WIDTH-1:0] DEF_STEP     = 32'h00266666,
   parameter int               DEF_MAX_ITER = 256,
   parameter int               MAX_ITER_CAP = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    run,
   input  logic                    frame_busy,
   input  logic                    frame_done,
   output logic                    frame_start,
   output logic signed [WIDTH-1:0] c_re_start,
   output logic signed [WIDTH-1:0] c_im_start,
   output logic signed [WIDTH-1:0] step,
   output logic [ITER_W-1:0]       max_iter,
   output logic                    wrap
);

   localparam int                  MUL_BITS  = 9;
   localparam logic [MUL_BITS-1:0] HALF_H    = MUL_BITS'(H_RES / 2);
   localparam logic [MUL_BITS-1:0] HALF_V    = MUL_BITS'(V_RES / 2);
   localparam logic [3:0]          LAST_BIT  = 4'(MUL_BITS - 1);
   localparam logic [ITER_W-1:0]   ITER_HOME =
      ITER_W'((DEF_MAX_ITER < MAX_ITER_CAP) ? DEF_MAX_ITER : MAX_ITER_CAP);

   typedef enum logic [2:0] {
      S_BOOT,
      S_HOLD,
      S_START,
      S_WAIT,
      S_CALC,
      S_MUL,
      S_UPDATE
   } state_t;

   state_t state_reg;
   state_t state_next;

   logic                    boot_hold_reg;
   logic signed [WIDTH-1:0] step_reg;
   logic signed [WIDTH-1:0] re_reg;
   logic signed [WIDTH-1:0] im_reg;
   logic signed [WIDTH-1:0] nstep_reg;
   logic [WIDTH-1:0]        mcand_reg;
   logic [MUL_BITS-1:0]     hmul_reg;
   logic [MUL_BITS-1:0]     vmul_reg;
   logic [3:0]              bit_reg;
   logic [WIDTH-1:0]        acc_h_reg;
   logic [WIDTH-1:0]        acc_v_reg;
   logic                    wrap_flag_reg;
   logic                    wrap_reg;
   logic signed [WIDTH-1:0] nstep_calc;

   assign nstep_calc = step_reg - (step_reg >>> ZOOM_SHIFT);

   // Reset release is delayed by one edge so BOOT always sees a clean, settled cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         boot_hold_reg <= 1'b1;
      end else begin
         boot_hold_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_BOOT;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      frame_start = 1'b0;
      case (state_reg)
         S_BOOT: begin
            if (!boot_hold_reg) begin
               state_next = S_HOLD;
            end
         end
         S_HOLD: begin
            if (run) begin
               state_next = S_START;
            end
         end
         S_START: begin
            frame_start = 1'b1;
            state_next  = S_WAIT;
         end
         S_WAIT: begin
            if (frame_done && !frame_busy) begin
               state_next = S_CALC;
            end
         end
         S_CALC: begin
            state_next = S_MUL;
         end
         S_MUL: begin
            if (bit_reg == LAST_BIT) begin
               state_next = S_UPDATE;
            end
         end
         S_UPDATE: begin
            state_next = S_HOLD;
         end
         default: begin
            state_next = S_BOOT;
         end
      endcase
   end

   // Multiplicand shifts left while the half-resolution multipliers shift right,
   // so each MUL cycle only needs to look at bit 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nstep_reg     <= '0;
         mcand_reg     <= '0;
         hmul_reg      <= '0;
         vmul_reg      <= '0;
         bit_reg       <= '0;
         acc_h_reg     <= '0;
         acc_v_reg     <= '0;
         wrap_flag_reg <= 1'b0;
      end else begin
         case (state_reg)
            S_CALC: begin
               nstep_reg     <= nstep_calc;
               mcand_reg     <= nstep_calc;
               hmul_reg      <= HALF_H;
               vmul_reg      <= HALF_V;
               bit_reg       <= '0;
               acc_h_reg     <= '0;
               acc_v_reg     <= '0;
               wrap_flag_reg <= (nstep_calc == step_reg) || nstep_calc[WIDTH-1] ||
                                (nstep_calc == '0);
            end
            S_MUL: begin
               acc_h_reg <= acc_h_reg + (hmul_reg[0] ? mcand_reg : '0);
               acc_v_reg <= acc_v_reg + (vmul_reg[0] ? mcand_reg : '0);
               mcand_reg <= mcand_reg << 1;
               hmul_reg  <= hmul_reg >> 1;
               vmul_reg  <= vmul_reg >> 1;
               bit_reg   <= bit_reg + 4'd1;
            end
            default: begin
            end
         endcase
      end
   end

   // Viewport registers change only in UPDATE, which is unreachable while a frame is in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_reg <= DEF_STEP;
         re_reg   <= DEF_RE_START;
         im_reg   <= DEF_IM_START;
         wrap_reg <= 1'b0;
      end else begin
         wrap_reg <= 1'b0;
         if (state_reg == S_UPDATE) begin
            if (wrap_flag_reg) begin
               step_reg <= DEF_STEP;
               re_reg   <= DEF_RE_START;
               im_reg   <= DEF_IM_START;
               wrap_reg <= 1'b1;
            end else begin
               step_reg <= nstep_reg;
               re_reg   <= TARGET_RE - acc_h_reg;
               im_reg   <= TARGET_IM - acc_v_reg;
            end
         end
      end
   end

`ifdef VIEWPORT_ITER_RAMP_EN
   localparam logic [ITER_W-1:0] ITER_CAP = ITER_W'(MAX_ITER_CAP);

   logic [ITER_W-1:0] iter_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iter_reg <= ITER_HOME;
      end else if (state_reg == S_UPDATE) begin
         if (wrap_flag_reg) begin
            iter_reg <= ITER_HOME;
         end else if (iter_reg < ITER_CAP) begin
            iter_reg <= iter_reg + ITER_W'(1);
         end
      end
   end

   assign max_iter = iter_reg;
`else
   assign max_iter = ITER_HOME;
`endif

   assign step       = step_reg;
   assign c_re_start = re_reg;
   assign c_im_start = im_reg;
   assign wrap       = wrap_reg;

endmodule

// File: tb/tb_viewport_ctrl.sv
// Randomized bench for viewport_ctrl: a frame-level zoom model predicts every viewport,
// and an emulated scheduler checks start latency, wrap pulses and ignored completions.
module tb_viewport_ctrl;

   localparam logic [31:0] TARGET_RE = 32'hF4147AE1;
   localparam logic [31:0] TARGET_IM = 32'h01CFDF3B;
   localparam logic [31:0] DEF_RE    = 32'hE0000000;
   localparam logic [31:0] DEF_IM    = 32'hF319999A;
   localparam logic [31:0] DEF_STEP  = 32'h00266666;
   localparam int          DEF_ITER  = 256;
   localparam int          ITER_CAP  = 1024;
   localparam int          HALF_H    = 160;
   localparam int          HALF_V    = 86;
   localparam int          N_FRAMES  = 1100;

   logic               clk = 1'b0;
   logic               rst;
   logic               run;
   logic               frame_busy;
   logic               frame_done;
   logic               frame_start;
   logic signed [31:0] c_re_start;
   logic signed [31:0] c_im_start;
   logic signed [31:0] step;
   logic [15:0]        max_iter;
   logic               wrap;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] m_re;
   logic [31:0] m_im;
   logic [31:0] m_step;
   int          m_iter;
   bit          m_wrap;

   always #5 clk = ~clk;

   viewport_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .frame_busy (frame_busy),
      .frame_done (frame_done),
      .frame_start(frame_start),
      .c_re_start (c_re_start),
      .c_im_start (c_im_start),
      .step       (step),
      .max_iter   (max_iter),
      .wrap       (wrap)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_home();
      m_re   = DEF_RE;
      m_im   = DEF_IM;
      m_step = DEF_STEP;
      m_iter = DEF_ITER;
   endtask

   // One zoom step: shrink the step, re-centre the frame on the target.
   task automatic model_advance();
      longint s;
      longint ns;
      s  = longint'($signed(m_step));
      ns = s - (s >>> 6);
      if (ns == s || ns <= 0) begin
         model_home();
         m_wrap = 1'b1;
      end else begin
         m_wrap = 1'b0;
         m_step = ns[31:0];
         m_re   = TARGET_RE - 32'(ns * HALF_H);
         m_im   = TARGET_IM - 32'(ns * HALF_V);
`ifdef VIEWPORT_ITER_RAMP_EN
         if (m_iter < ITER_CAP) m_iter++;
`endif
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_re"},   c_re_start, m_re);
      check({tag, "_im"},   c_im_start, m_im);
      check({tag, "_step"}, step, m_step);
      check({tag, "_iter"}, 32'(max_iter), 32'(m_iter));
   endtask

   // Called #1 after a posedge with rst high; releases it and expects start on the 3rd edge.
   task automatic boot_check();
      int first;
      first = -1;
      rst   = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (frame_start) begin
            first = i;
            break;
         end
      end
      check("boot_latency", first, 3);
      check_outputs("boot");
   endtask

   // Entered with frame_start high; returns with the next frame_start high.
   task automatic do_frame(input bit rst_mid);
      int b;
      int lat;
      int wraps;
      int spur_k;
      bit drop_run;
      bit busy_pulse;
      bit extra_fs;
      bit fs_seen;

      check_outputs("fs");
      b          = $urandom_range(1, 5);
      busy_pulse = ($urandom_range(0, 1) == 1);
      spur_k     = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : 0;
      drop_run   = ($urandom_range(0, 7) == 0);
      extra_fs   = 1'b0;

      frame_busy = 1'b1;
      tick();
      check("fs_single", frame_start, 1'b0);
      for (int i = 0; i < b; i++) begin
         frame_done = busy_pulse && (i == 0);
         tick();
         frame_done = 1'b0;
         extra_fs |= frame_start;
      end
      check("busy_no_start", extra_fs, 1'b0);
      check("busy_hold_step", step, m_step);

      frame_busy = 1'b0;
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      model_advance();
      if (drop_run) run = 1'b0;

      lat   = -1;
      wraps = 0;
      for (int k = 1; k <= 20; k++) begin
         if (k == spur_k) frame_done = 1'b1;
         if (rst_mid && k == 5) begin
            rst = 1'b1;
            #1;
            model_home();
            check_outputs("rst_mid");
            check("rst_mid_fs", frame_start, 1'b0);
            check("rst_mid_wrap", wrap, 1'b0);
            frame_done = 1'b0;
            run        = 1'b1;
            tick();
            tick();
            boot_check();
            return;
         end
         tick();
         frame_done = 1'b0;
         if (wrap) wraps++;
         if (k == 11) check_outputs("upd");
         if (frame_start) begin
            lat = k;
            break;
         end
      end
      check("wrap_pulses", wraps, m_wrap ? 1 : 0);

      if (drop_run) begin
         check("hold_no_start", lat, -1);
         run     = 1'b1;
         fs_seen = 1'b0;
         lat     = -1;
         for (int j = 1; j <= 4; j++) begin
            tick();
            if (frame_start) begin
               lat     = j;
               fs_seen = 1'b1;
               break;
            end
         end
         check("run_rise_start", fs_seen && lat <= 2, 1'b1);
      end else begin
         check("done_to_start", lat, 12);
      end
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst        = 1'b1;
      run        = 1'b1;
      frame_busy = 1'b0;
      frame_done = 1'b0;
      model_home();
      m_wrap = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs("reset");
      check("reset_fs", frame_start, 1'b0);
      check("reset_wrap", wrap, 1'b0);

      boot_check();
      for (int f = 0; f < N_FRAMES; f++) begin
         do_frame(f == 3);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
